// File: rtl/mem_calc_pkg.sv
// Shared definitions for the load/store unit: opcodes, size codes, bundle layout.
package mem_calc_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Fixed-position fields at the bottom of the bundle
  localparam int OFF_OP1 = 0;
  localparam int OFF_OP2 = 32;
  localparam int OFF_RD  = 64;

  // Fields above rd move with the register tag and branch mask widths
  function automatic int off_imm(input int wreg);
    return OFF_RD + wreg;
  endfunction

  function automatic int off_pc(input int wreg);
    return off_imm(wreg) + 32;
  endfunction

  function automatic int off_uop(input int wreg);
    return off_pc(wreg) + 32;
  endfunction

  function automatic int off_brm(input int wreg);
    return off_uop(wreg) + 7;
  endfunction

  function automatic int off_func(input int wreg, input int wbrm);
    return off_brm(wreg) + wbrm;
  endfunction

  function automatic int off_valid(input int wreg, input int wbrm);
    return off_func(wreg, wbrm) + 10;
  endfunction

endpackage

// File: rtl/mem_calc_dmem.sv
// Private data memory: byte-enable synchronous write, asynchronous read.
module mem_calc_dmem #(
  parameter int MEM_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Write only the enabled byte lanes; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_calc_m.sv
// Load/store execution unit: effective address, lane steering, load extension.
module mem_calc_m
  import mem_calc_pkg::*;
#(
  parameter int WIDTH     = 159,
  parameter int WIDTH_REG = 7,
  parameter int WIDTH_BRM = 6,
  parameter int MEM_WORDS = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_instr,
  output logic [31:0]          o_data,
  output logic [WIDTH_REG-1:0] o_addr,
  output logic                 o_valid
);

  localparam int AW       = $clog2(MEM_WORDS);
  localparam int P_IMM    = off_imm(WIDTH_REG);
  localparam int P_PC     = off_pc(WIDTH_REG);
  localparam int P_UOP    = off_uop(WIDTH_REG);
  localparam int P_BRM    = off_brm(WIDTH_REG);
  localparam int P_FUNC   = off_func(WIDTH_REG, WIDTH_BRM);
  localparam int P_VALID  = off_valid(WIDTH_REG, WIDTH_BRM);

  logic [31:0]          op1, op2, imm, ea;
  logic [WIDTH_REG-1:0] rd;
  logic [6:0]           uop;
  logic [9:0]           func;
  logic [2:0]           f3;
  logic                 valid, is_load, is_store, we;
  logic [3:0]           be;
  logic [31:0]          wdata, rdata, ld_res;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;

  assign op1   = i_instr[OFF_OP1 +: 32];
  assign op2   = i_instr[OFF_OP2 +: 32];
  assign rd    = i_instr[OFF_RD +: WIDTH_REG];
  assign imm   = i_instr[P_IMM +: 32];
  assign uop   = i_instr[P_UOP +: 7];
  assign func  = i_instr[P_FUNC +: 10];
  assign valid = i_instr[P_VALID];
  assign f3    = func[2:0];

  // pc, branch mask, upper func bits and high address bits play no part here
  logic unused_bits;
  assign unused_bits = ^{i_instr[P_PC +: 32], i_instr[P_BRM +: WIDTH_BRM], func[9:3],
                         ea[31:AW+2]};

  assign ea       = op1 + imm;
  assign is_load  = valid && (uop == OP_LOAD);
  assign is_store = valid && (uop == OP_STORE);
  // Gating with reset drops a store that coincides with reset assertion
  assign we       = is_store && i_rst_n;

  // Store lane steering: replicate data across lanes, enable only the target bytes
  always_comb begin
    be    = 4'b1111;
    wdata = op2;
    case (f3)
      F3_B: begin
        be    = 4'b0001 << ea[1:0];
        wdata = {4{op2[7:0]}};
      end
      F3_H: begin
        be    = ea[1] ? 4'b1100 : 4'b0011;
        wdata = {2{op2[15:0]}};
      end
      default: ;
    endcase
  end

  mem_calc_dmem #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_dmem (
    .clk   (i_clk),
    .we    (we),
    .be    (be),
    .addr  (ea[AW+1:2]),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Load extract and sign/zero extension from the addressed lane
  always_comb begin
    ld_byte = rdata[8*ea[1:0] +: 8];
    ld_half = ea[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_B:    ld_res = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_res = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_res = {24'b0, ld_byte};
      F3_HU:   ld_res = {16'b0, ld_half};
      default: ld_res = rdata;
    endcase
  end

  // Result registers: pulse valid per load, hold data/tag otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_addr  <= '0;
    end else begin
      o_valid <= is_load;
      if (is_load) begin
        o_data <= ld_res;
        o_addr <= rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_calc_m.sv
// Directed self-checking bench for the load/store unit.
module tb_mem_calc_m;

  localparam logic [6:0] U_LD = 7'b0000011;
  localparam logic [6:0] U_ST = 7'b0100011;

  logic         i_clk;
  logic         i_rst_n;
  logic [158:0] i_instr;
  logic [31:0]  o_data;
  logic [6:0]   o_addr;
  logic         o_valid;

  int checks;
  int errors;

  mem_calc_m dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_instr (i_instr),
    .o_data  (o_data),
    .o_addr  (o_addr),
    .o_valid (o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Assemble a bundle; pc, brmask and func[9:3] carry junk that must be ignored
  function automatic logic [158:0] mk(input logic v, input logic [6:0] uop, input logic [2:0] f3,
                                      input logic [31:0] op1, input logic [31:0] op2,
                                      input logic [31:0] imm, input logic [6:0] rd);
    return {v, 7'h55, f3, 6'h2A, uop, 32'h0000_1000, imm, rd, op2, op1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a bundle for one rising edge, then settle away from the edge
  task automatic step(input logic [158:0] b);
    i_instr = b;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_ld(input string tag, input logic [31:0] d, input logic [6:0] a);
    chk({tag, "_v"}, {31'b0, o_valid}, 32'd1);
    chk({tag, "_d"}, o_data, d);
    chk({tag, "_a"}, {25'b0, o_addr}, {25'b0, a});
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    i_rst_n = 1'b0;
    i_instr = '0;

    // Reset state
    step('0);
    step('0);
    chk("rst_v", {31'b0, o_valid}, 32'd0);
    chk("rst_d", o_data, 32'd0);
    chk("rst_a", {25'b0, o_addr}, 32'd0);

    i_rst_n = 1'b1;
    step(mk(1'b0, U_LD, 3'b010, 32'd0, 32'd0, 32'd0, 7'd9));
    chk("idle_v", {31'b0, o_valid}, 32'd0);

    // SW then LW at ea=2 (word 0)
    step(mk(1'b1, U_ST, 3'b010, 32'd1, 32'd3, 32'd1, 7'd3));
    chk("sw_v", {31'b0, o_valid}, 32'd0);
    step(mk(1'b1, U_LD, 3'b010, 32'd1, 32'd3, 32'd1, 7'd3));
    chk_ld("lw0", 32'd3, 7'd3);

    // Non-memory uop and an invalid store must not disturb word 0
    step(mk(1'b1, 7'd0, 3'b010, 32'd2, 32'd4, 32'd3, 7'd4));
    chk("nop_v", {31'b0, o_valid}, 32'd0);
    chk("nop_hold_d", o_data, 32'd3);
    step(mk(1'b0, U_ST, 3'b010, 32'd0, 32'h55, 32'd0, 7'd4));
    chk("inv_v", {31'b0, o_valid}, 32'd0);
    step(mk(1'b1, U_LD, 3'b010, 32'd0, 32'd0, 32'd0, 7'd1));
    chk_ld("lw_after_nop", 32'd3, 7'd1);

    // Byte store into lane 1 of word 1
    step(mk(1'b1, U_ST, 3'b010, 32'd4, 32'd0, 32'd0, 7'd0));
    step(mk(1'b1, U_ST, 3'b000, 32'd5, 32'h0000_0080, 32'd0, 7'd0));
    step(mk(1'b1, U_LD, 3'b000, 32'd5, 32'd0, 32'd0, 7'd10));
    chk_ld("lb", 32'hFFFF_FF80, 7'd10);
    step(mk(1'b1, U_LD, 3'b100, 32'd5, 32'd0, 32'd0, 7'd11));
    chk_ld("lbu", 32'h0000_0080, 7'd11);
    step(mk(1'b1, U_LD, 3'b010, 32'd4, 32'd0, 32'd0, 7'd12));
    chk_ld("lw_b", 32'h0000_8000, 7'd12);

    // Half store into upper half of word 2; ea=16+(-6)=10
    step(mk(1'b1, U_ST, 3'b010, 32'd8, 32'd0, 32'd0, 7'd0));
    step(mk(1'b1, U_ST, 3'b001, 32'd16, 32'h1234_ABCD, 32'hFFFF_FFFA, 7'd0));
    step(mk(1'b1, U_LD, 3'b001, 32'd10, 32'd0, 32'd0, 7'd13));
    chk_ld("lh", 32'hFFFF_ABCD, 7'd13);
    step(mk(1'b1, U_LD, 3'b101, 32'd10, 32'd0, 32'd0, 7'd14));
    chk_ld("lhu", 32'h0000_ABCD, 7'd14);
    step(mk(1'b1, U_LD, 3'b001, 32'd8, 32'd0, 32'd0, 7'd15));
    chk_ld("lh_lo", 32'h0000_0000, 7'd15);
    step(mk(1'b1, U_LD, 3'b000, 32'd11, 32'd0, 32'd0, 7'd16));
    chk_ld("lb_l3", 32'hFFFF_FFAB, 7'd16);
    step(mk(1'b1, U_LD, 3'b010, 32'd1032, 32'd0, 32'd0, 7'd17));
    chk_ld("lw_wrap", 32'hABCD_0000, 7'd17);

    // Back-to-back loads, then idle holds the last result
    step(mk(1'b1, U_LD, 3'b010, 32'd0, 32'd0, 32'd0, 7'd5));
    chk_ld("b2b_0", 32'd3, 7'd5);
    step(mk(1'b1, U_LD, 3'b010, 32'd4, 32'd0, 32'd0, 7'd6));
    chk_ld("b2b_1", 32'h0000_8000, 7'd6);
    step('0);
    chk("idle2_v", {31'b0, o_valid}, 32'd0);
    chk("idle2_d", o_data, 32'h0000_8000);
    chk("idle2_a", {25'b0, o_addr}, 32'd6);

    // Load directly after store to the same word
    step(mk(1'b1, U_ST, 3'b010, 32'd12, 32'hDEAD_BEEF, 32'd0, 7'd0));
    step(mk(1'b1, U_LD, 3'b010, 32'd12, 32'd0, 32'd0, 7'd7));
    chk_ld("raw", 32'hDEAD_BEEF, 7'd7);

    // Reset mid-stream clears outputs at once; a store under reset is dropped
    step(mk(1'b1, U_LD, 3'b010, 32'd0, 32'd0, 32'd0, 7'd8));
    chk("pre_rst_v", {31'b0, o_valid}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_v", {31'b0, o_valid}, 32'd0);
    chk("mid_rst_d", o_data, 32'd0);
    chk("mid_rst_a", {25'b0, o_addr}, 32'd0);
    step(mk(1'b1, U_ST, 3'b010, 32'd12, 32'h1111_1111, 32'd0, 7'd0));
    i_rst_n = 1'b1;
    step(mk(1'b1, U_LD, 3'b010, 32'd12, 32'd0, 32'd0, 7'd9));
    chk_ld("st_in_rst", 32'hDEAD_BEEF, 7'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
